memory_loader: RTL and testbench

- Byte-stream to BRAM writer; the write-side companion of the button-driven BRAM read port. It shares the same BRAM port conventions (32-bit byte address, always-enabled port).
- Accepts a framed byte stream, typically from the UART receiver, over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them to BRAM at consecutive word addresses.
- Used to load program/data images before the CPU is released from reset.

---
 rtl/memory_loader.sv | 177 +++++++++++++++++
 tb/tb_memory_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_loader.sv
// Byte-stream to BRAM loader: frames a little-endian word count plus payload words into consecutive BRAM writes.
// Optional trailing checksum byte enabled by defining MEMORY_LOADER_CHECKSUM_EN.
module memory_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] MAX_WORDS = 32'd16384
) (
   input  logic        CLK,
   input  logic        RSTN,
   input  logic        start,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        bram_en,
   output logic [3:0]  bram_we,
   output logic [31:0] bram_addr,
   output logic [31:0] bram_din,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] loaded_words
);

`ifdef MEMORY_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE} state_t;
   localparam state_t AFTER_PAYLOAD = CHK;
`else
   typedef enum logic [2:0] {IDLE, HDR, DATA, DONE} state_t;
   localparam state_t AFTER_PAYLOAD = DONE;
`endif

   state_t state, next_state;

   logic [1:0]  byte_cnt;
   logic [23:0] asm_reg;
   logic [31:0] word_total;
   logic [31:0] word;
   logic        accept;
   logic        last_lane;
   logic        last_word;

`ifdef MEMORY_LOADER_CHECKSUM_EN
   logic [7:0]  sum;
`endif

   // The fourth byte of a word is never stored; it is merged straight into the write data.
   assign word      = {in_data, asm_reg};
   assign accept    = in_ready & in_valid;
   assign last_lane = (byte_cnt == 2'd3);
   assign last_word = ((loaded_words + 32'd1) == word_total);

   assign bram_en  = 1'b1;
   assign done     = (state == DONE);
`ifdef MEMORY_LOADER_CHECKSUM_EN
   assign in_ready = (state == HDR) || (state == DATA) || (state == CHK);
`else
   assign in_ready = (state == HDR) || (state == DATA);
`endif
   assign busy     = in_ready;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = HDR;
            end
         end
         HDR: begin
            if (accept && last_lane) begin
               if (word > MAX_WORDS) begin
                  next_state = DONE;
               end else if (word == 32'd0) begin
                  next_state = AFTER_PAYLOAD;
               end else begin
                  next_state = DATA;
               end
            end
         end
         DATA: begin
            if (accept && last_lane && last_word) begin
               next_state = AFTER_PAYLOAD;
            end
         end
`ifdef MEMORY_LOADER_CHECKSUM_EN
         CHK: begin
            if (accept) begin
               next_state = DONE;
            end
         end
`endif
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         byte_cnt     <= 2'd0;
         asm_reg      <= 24'd0;
         word_total   <= 32'd0;
         bram_we      <= 4'h0;
         bram_addr    <= 32'd0;
         bram_din     <= 32'd0;
         error        <= 1'b0;
         loaded_words <= 32'd0;
`ifdef MEMORY_LOADER_CHECKSUM_EN
         sum          <= 8'd0;
`endif
      end else begin
         bram_we <= 4'h0;
         case (state)
            IDLE: begin
               if (start) begin
                  error        <= 1'b0;
                  loaded_words <= 32'd0;
                  byte_cnt     <= 2'd0;
                  asm_reg      <= 24'd0;
`ifdef MEMORY_LOADER_CHECKSUM_EN
                  sum          <= 8'd0;
`endif
               end
            end
            HDR: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (last_lane) begin
                     word_total <= word;
                     if (word > MAX_WORDS) begin
                        error <= 1'b1;
                     end
                  end else begin
                     asm_reg <= {in_data, asm_reg[23:8]};
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef MEMORY_LOADER_CHECKSUM_EN
                  sum      <= sum + in_data;
`endif
                  if (last_lane) begin
                     bram_we      <= 4'hF;
                     bram_din     <= word;
                     bram_addr    <= BASE_ADDR + {loaded_words[29:0], 2'b00};
                     loaded_words <= loaded_words + 32'd1;
                  end else begin
                     asm_reg <= {in_data, asm_reg[23:8]};
                  end
               end
            end
`ifdef MEMORY_LOADER_CHECKSUM_EN
            CHK: begin
               if (accept && (in_data != sum)) begin
                  error <= 1'b1;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_loader.sv
// Directed self-checking bench for memory_loader; checksum cases run when MEMORY_LOADER_CHECKSUM_EN is defined.
module tb_memory_loader;

   logic        CLK;
   logic        RSTN;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [31:0] bram_addr;
   logic [31:0] bram_din;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] loaded_words;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  fb [0:15];
   int          flen;

   logic [31:0] wr_addr [0:63];
   logic [31:0] wr_data [0:63];
   int          wr_cnt   = 0;
   int          done_cnt = 0;
   int          w0;
   int          d0;

   memory_loader dut (
      .CLK          (CLK),
      .RSTN         (RSTN),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .bram_en      (bram_en),
      .bram_we      (bram_we),
      .bram_addr    (bram_addr),
      .bram_din     (bram_din),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .loaded_words (loaded_words)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Write/done log sampled mid-cycle, away from the rising edge.
   always @(negedge CLK) begin
      if (bram_we != 4'h0) begin
         if (wr_cnt < 64) begin
            wr_addr[wr_cnt] <= bram_addr;
            wr_data[wr_cnt] <= bram_din;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic startPulse();
      start = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input bit gap);
      bit r;
      bit ok;
      if (gap) begin
         in_valid = 1'b0;
         @(posedge CLK);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge CLK);
         r = in_ready;
         @(posedge CLK);
         #1;
         if (r) ok = 1'b1;
      end
      if (!ok) checkOutput("byte_timeout", 32'd0, 32'd1);
   endtask

   task automatic applyStimulus(input bit gap);
      for (int i = 0; i < flen; i++) begin
         sendByte(fb[i], gap);
      end
      in_valid = 1'b0;
   endtask

   task automatic setTwoWordFrame();
      fb[0] = 8'h02; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
      fb[4] = 8'h78; fb[5] = 8'h56; fb[6] = 8'h34; fb[7] = 8'h12;
      fb[8] = 8'hEF; fb[9] = 8'hBE; fb[10] = 8'hAD; fb[11] = 8'hDE;
      flen = 12;
`ifdef MEMORY_LOADER_CHECKSUM_EN
      fb[12] = 8'h4C;
      flen = 13;
`endif
   endtask

   task automatic checkTwoWordFrame(input string tag);
`ifndef MEMORY_LOADER_CHECKSUM_EN
      checkOutput({tag, "_done_with_write"}, {31'd0, done}, 32'd1);
      checkOutput({tag, "_last_we"}, {28'd0, bram_we}, 32'hF);
      checkOutput({tag, "_last_addr"}, bram_addr, 32'h4);
`else
      checkOutput({tag, "_done_after_chk"}, {31'd0, done}, 32'd1);
`endif
      waitCycles(3);
      checkOutput({tag, "_writes"}, wr_cnt - w0, 32'd2);
      checkOutput({tag, "_addr0"}, wr_addr[w0], 32'h0);
      checkOutput({tag, "_data0"}, wr_data[w0], 32'h12345678);
      checkOutput({tag, "_addr1"}, wr_addr[w0 + 1], 32'h4);
      checkOutput({tag, "_data1"}, wr_data[w0 + 1], 32'hDEADBEEF);
      checkOutput({tag, "_dones"}, done_cnt - d0, 32'd1);
      checkOutput({tag, "_loaded"}, loaded_words, 32'd2);
      checkOutput({tag, "_error"}, {31'd0, error}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      RSTN     = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #3;
      checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_error", {31'd0, error}, 32'd0);
      checkOutput("rst_we", {28'd0, bram_we}, 32'd0);
      checkOutput("rst_loaded", loaded_words, 32'd0);
      checkOutput("bram_en", {31'd0, bram_en}, 32'd1);
      #20;
      RSTN = 1'b1;
      waitCycles(2);

      w0 = wr_cnt; d0 = done_cnt;
      setTwoWordFrame();
      startPulse();
      checkOutput("f1_busy_after_start", {31'd0, busy}, 32'd1);
      applyStimulus(1'b0);
      checkTwoWordFrame("f1");

      // Bytes offered while idle must be ignored.
      w0 = wr_cnt; d0 = done_cnt;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         waitCycles(1);
         checkOutput("idle_ready", {31'd0, in_ready}, 32'd0);
      end
      startPulse();
      applyStimulus(1'b1);
      checkTwoWordFrame("f2");

      w0 = wr_cnt; d0 = done_cnt;
      fb[0] = 8'h00; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
      flen = 4;
`ifdef MEMORY_LOADER_CHECKSUM_EN
      fb[4] = 8'h00;
      flen = 5;
`endif
      startPulse();
      applyStimulus(1'b0);
      checkOutput("zero_done", {31'd0, done}, 32'd1);
      waitCycles(3);
      checkOutput("zero_writes", wr_cnt - w0, 32'd0);
      checkOutput("zero_dones", done_cnt - d0, 32'd1);
      checkOutput("zero_loaded", loaded_words, 32'd0);
      checkOutput("zero_error", {31'd0, error}, 32'd0);

      // 0x4001 words is one beyond the default limit; no checksum byte is expected.
      w0 = wr_cnt; d0 = done_cnt;
      fb[0] = 8'h01; fb[1] = 8'h40; fb[2] = 8'h00; fb[3] = 8'h00;
      flen = 4;
      startPulse();
      applyStimulus(1'b0);
      checkOutput("ovf_done", {31'd0, done}, 32'd1);
      checkOutput("ovf_error", {31'd0, error}, 32'd1);
      waitCycles(3);
      checkOutput("ovf_writes", wr_cnt - w0, 32'd0);
      checkOutput("ovf_dones", done_cnt - d0, 32'd1);
      checkOutput("ovf_sticky", {31'd0, error}, 32'd1);
      checkOutput("ovf_ready", {31'd0, in_ready}, 32'd0);

      startPulse();
      checkOutput("restart_clears_error", {31'd0, error}, 32'd0);

      // Abandon a frame after one payload byte via asynchronous reset.
      w0 = wr_cnt;
      fb[0] = 8'h02; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h11;
      flen = 5;
      applyStimulus(1'b0);
      #2;
      RSTN = 1'b0;
      #1;
      checkOutput("arst_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_addr", bram_addr, 32'd0);
      checkOutput("arst_din", bram_din, 32'd0);
      checkOutput("arst_we", {28'd0, bram_we}, 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h22;
      waitCycles(4);
      in_valid = 1'b0;
      checkOutput("arst_no_writes", wr_cnt - w0, 32'd0);
      RSTN = 1'b1;
      waitCycles(2);

      w0 = wr_cnt; d0 = done_cnt;
      setTwoWordFrame();
      startPulse();
      applyStimulus(1'b0);
      checkTwoWordFrame("f3");

`ifdef MEMORY_LOADER_CHECKSUM_EN
      w0 = wr_cnt;
      fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00;
      fb[4] = 8'h01; fb[5] = 8'h02; fb[6] = 8'h03; fb[7] = 8'h04;
      fb[8] = 8'h0A;
      flen = 9;
      startPulse();
      applyStimulus(1'b0);
      checkOutput("cs_good_done", {31'd0, done}, 32'd1);
      checkOutput("cs_good_error", {31'd0, error}, 32'd0);
      waitCycles(2);
      checkOutput("cs_good_writes", wr_cnt - w0, 32'd1);
      checkOutput("cs_good_data", wr_data[w0], 32'h04030201);

      w0 = wr_cnt;
      fb[8] = 8'h0B;
      startPulse();
      applyStimulus(1'b0);
      checkOutput("cs_bad_done", {31'd0, done}, 32'd1);
      checkOutput("cs_bad_error", {31'd0, error}, 32'd1);
      waitCycles(2);
      checkOutput("cs_bad_writes", wr_cnt - w0, 32'd1);
      checkOutput("cs_bad_data", wr_data[w0], 32'h04030201);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
